// File: rtl/ccff_bitstream_loader_if.sv
// Purpose : Signal bundle between a bitstream source and ccff_bitstream_loader.
// Ports   : start, s_data/s_valid/s_ready (word stream), ccff_head,
//           prog_clk_en, ccff_tail (chain side), busy, done (status).
//           rb_data/rb_valid exist only when CCFF_READBACK_EN is defined.
// master  : bitstream source / chain side (drives start, stream, tail).
// slave   : the loader.
interface ccff_bitstream_loader_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              prog_clk_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output start, s_data, s_valid, ccff_tail,
    input  s_ready, ccff_head, prog_clk_en, busy, done, rb_data, rb_valid
  );
  modport slave (
    input  start, s_data, s_valid, ccff_tail,
    output s_ready, ccff_head, prog_clk_en, busy, done, rb_data, rb_valid
  );
`else
  modport master (
    output start, s_data, s_valid, ccff_tail,
    input  s_ready, ccff_head, prog_clk_en, busy, done
  );
  modport slave (
    input  start, s_data, s_valid, ccff_tail,
    output s_ready, ccff_head, prog_clk_en, busy, done
  );
`endif
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Purpose : Loads a ccff configuration chain. Bitstream words arrive on a
//           valid/ready stream and are serialised MSB-first onto ccff_head;
//           prog_clk_en gates prog_clk so the chain only advances on a valid bit.
// Ports   : prog_clk, prog_reset_n (async, active-low);
//           ccff (slave modport): start, s_data, s_valid, s_ready, ccff_head,
//           prog_clk_en, ccff_tail, busy, done [, rb_data, rb_valid].
// Option  : define CCFF_READBACK_EN to deserialise ccff_tail into rb_data/rb_valid.
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned DATA_W    = 8
) (
  input logic                    prog_clk,
  input logic                    prog_reset_n,
  ccff_bitstream_loader_if.slave ccff
);
  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;    // index of the chain bit currently on ccff_head
  logic [WB_W-1:0]   r_word_bits;  // bits of the current word still to present, incl. current
  logic              r_s_ready;
  logic              r_ccff_head;
  logic              r_prog_clk_en;
  logic              r_busy;
  logic              r_done;

  logic              w_take;
  logic              w_last_chain;
  logic              w_last_word_bit;
  logic              w_idx_last;
  logic              w_load_rdy;
  logic [CNT_W-1:0]  w_load_idx;
  logic [WB_W-1:0]   w_load_wb;

  // Bits of a word that land in the chain when it starts at chain index idx.
  function automatic logic [WB_W-1:0] word_len(input logic [CNT_W-1:0] idx);
    int unsigned rem;
    rem = CHAIN_LEN - 32'(idx);
    return (rem < DATA_W) ? WB_W'(rem) : WB_W'(DATA_W);
  endfunction

  assign w_take          = ccff.s_valid & r_s_ready;
  assign w_last_chain    = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_last_word_bit = (r_word_bits == WB_W'(1));
  // Chain index of the next bit: a FETCH resumes at r_bit_cnt, SHIFT moves one on.
  assign w_load_idx      = (r_state == SHIFT) ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
  assign w_idx_last      = (w_load_idx == CNT_W'(CHAIN_LEN - 1));
  assign w_load_wb       = word_len(w_load_idx);
  // A freshly loaded one-bit word is already on its final bit: ask for the next word.
  assign w_load_rdy      = (w_load_wb == WB_W'(1)) && !w_idx_last;

  // Load FSM; every output is registered against the state it is entering.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_word_bits   <= '0;
      r_s_ready     <= 1'b0;
      r_ccff_head   <= 1'b0;
      r_prog_clk_en <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ccff.start) begin
            r_state   <= FETCH;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        FETCH: begin
          // Chain frozen; the load below leaves this state.
        end
        SHIFT: begin
          if (w_last_chain) begin
            r_state       <= DONE;
            r_prog_clk_en <= 1'b0;
            r_s_ready     <= 1'b0;
            r_done        <= 1'b1;
            r_bit_cnt     <= '0;
          end else if (w_last_word_bit) begin
            // Stall unless a word is taken this cycle (overridden by the load).
            r_state       <= FETCH;
            r_prog_clk_en <= 1'b0;
            r_s_ready     <= 1'b1;
            r_bit_cnt     <= w_load_idx;
          end else begin
            r_ccff_head <= r_shift[DATA_W-1];
            r_shift     <= r_shift << 1;
            r_word_bits <= r_word_bits - WB_W'(1);
            r_bit_cnt   <= w_load_idx;
            r_s_ready   <= (r_word_bits == WB_W'(2)) && !w_idx_last;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase

      // Word accepted: its MSB goes straight onto ccff_head, no bubble.
      if (w_take) begin
        r_state       <= SHIFT;
        r_ccff_head   <= ccff.s_data[DATA_W-1];
        r_shift       <= ccff.s_data << 1;
        r_word_bits   <= w_load_wb;
        r_bit_cnt     <= w_load_idx;
        r_prog_clk_en <= 1'b1;
        r_s_ready     <= w_load_rdy;
      end
    end
  end

  assign ccff.s_ready     = r_s_ready;
  assign ccff.ccff_head   = r_ccff_head;
  assign ccff.prog_clk_en = r_prog_clk_en;
  assign ccff.busy        = r_busy;
  assign ccff.done        = r_done;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] r_rb_acc;
  logic [DATA_W-1:0] r_rb_data;
  logic [WB_W-1:0]   r_rb_cnt;
  logic              r_rb_valid;
  logic [DATA_W-1:0] w_rb_word;

  // Accumulator with the current tail bit dropped into its MSB-first slot.
  for (genvar g = 0; g < DATA_W; g++) begin : g_rb_slot
    assign w_rb_word[g] = (r_rb_cnt == WB_W'(DATA_W - 1 - g)) ? ccff.ccff_tail : r_rb_acc[g];
  end

  // Tail deserialiser; a final partial word is emitted left-aligned, zero-padded.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_rb_acc   <= '0;
      r_rb_data  <= '0;
      r_rb_cnt   <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_prog_clk_en) begin
        if ((r_rb_cnt == WB_W'(DATA_W - 1)) || w_last_chain) begin
          r_rb_valid <= 1'b1;
          r_rb_data  <= w_rb_word;
          r_rb_acc   <= '0;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_acc <= w_rb_word;
          r_rb_cnt <= r_rb_cnt + WB_W'(1);
        end
      end
    end
  end

  assign ccff.rb_data  = r_rb_data;
  assign ccff.rb_valid = r_rb_valid;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff.ccff_tail;
`endif
endmodule
